// File: rtl/mem_lane_arbiter_if.sv
// Single-port data memory bus shared by both memory-stage lanes.
interface mem_lane_arbiter_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [1:0]  mem_size;
  logic [31:0] mem_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_we, mem_re, mem_size,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_we, mem_re, mem_size,
    output mem_rdata
  );
endinterface

// File: rtl/mem_lane_arbiter.sv
// Serializes the two memory-stage lanes onto one single-port data memory,
// lane 0 first, stalling the pipeline one cycle per dual-access bundle.
module mem_lane_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          aluout_m_0,
  input  logic [31:0]          aluout_m_1,
  input  logic [31:0]          writedata_m_0,
  input  logic [31:0]          writedata_m_1,
  input  logic [3:0]           mem_ctrl_m_0,
  input  logic [3:0]           mem_ctrl_m_1,
  output logic [31:0]          readdata_m_0,
  output logic [31:0]          readdata_m_1,
  output logic                 stall_m,
  mem_lane_arbiter_if.master   mem,
  output logic [CNT_W-1:0]     conflict_count
);

  typedef enum logic {FIRST, SECOND} state_t;

  state_t             state_q, state_d;
  logic [31:0]        pend_addr_q, pend_addr_d;
  logic [31:0]        pend_wdata_q, pend_wdata_d;
  logic [3:0]         pend_ctrl_q, pend_ctrl_d;
  logic [31:0]        hold0_q, hold0_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               act0, act1, ld0, ld1, dual;
  logic [3:0]         iss_ctrl;
  logic [31:0]        iss_addr, iss_wdata;

  function automatic logic is_active(input logic [3:0] c);
    return c[3] | c[2];
  endfunction

  // A set store bit overrides the load bit.
  function automatic logic is_load(input logic [3:0] c);
    return ~c[3] & c[2];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign act0 = is_active(mem_ctrl_m_0);
  assign act1 = is_active(mem_ctrl_m_1);
  assign ld0  = is_load(mem_ctrl_m_0);
  assign ld1  = is_load(mem_ctrl_m_1);
  assign dual = act0 & act1;

  always_comb begin
    iss_ctrl     = 4'b0000;
    iss_addr     = 32'd0;
    iss_wdata    = 32'd0;
    stall_m      = 1'b0;
    readdata_m_0 = 32'd0;
    readdata_m_1 = 32'd0;
    if (!reset) begin
      if (state_q == SECOND) begin
        iss_ctrl     = pend_ctrl_q;
        iss_addr     = pend_addr_q;
        iss_wdata    = pend_wdata_q;
        readdata_m_0 = hold0_q;
        readdata_m_1 = is_load(pend_ctrl_q) ? mem.mem_rdata : 32'd0;
      end else if (act0) begin
        iss_ctrl     = mem_ctrl_m_0;
        iss_addr     = aluout_m_0;
        iss_wdata    = writedata_m_0;
        stall_m      = act1;
        readdata_m_0 = ld0 ? mem.mem_rdata : 32'd0;
      end else if (act1) begin
        iss_ctrl     = mem_ctrl_m_1;
        iss_addr     = aluout_m_1;
        iss_wdata    = writedata_m_1;
        readdata_m_1 = ld1 ? mem.mem_rdata : 32'd0;
      end
    end
  end

  assign mem.mem_addr    = iss_addr;
  assign mem.mem_wdata   = iss_wdata;
  assign mem.mem_we      = iss_ctrl[3];
  assign mem.mem_re      = is_load(iss_ctrl);
  assign mem.mem_size    = iss_ctrl[1:0];
  assign conflict_count  = cnt_q;

  always_comb begin
    state_d      = FIRST;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    pend_ctrl_d  = pend_ctrl_q;
    hold0_d      = hold0_q;
    cnt_d        = cnt_q;
    // Capture lane 1 and lane 0's load result so the bundle can finish next cycle.
    if (state_q == FIRST && dual) begin
      state_d      = SECOND;
      pend_addr_d  = aluout_m_1;
      pend_wdata_d = writedata_m_1;
      pend_ctrl_d  = mem_ctrl_m_1;
      hold0_d      = ld0 ? mem.mem_rdata : 32'd0;
      cnt_d        = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FIRST;
      pend_addr_q  <= 32'd0;
      pend_wdata_q <= 32'd0;
      pend_ctrl_q  <= 4'b0000;
      hold0_q      <= 32'd0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      pend_ctrl_q  <= pend_ctrl_d;
      hold0_q      <= hold0_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_lane_arbiter.sv
// Scoreboard bench: a bundle-level program-order model predicts every cycle's
// memory-port and read-data values; a negedge monitor pops and compares.
module tb_mem_lane_arbiter;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       aluout_m_0, aluout_m_1, writedata_m_0, writedata_m_1;
  logic [3:0]        mem_ctrl_m_0, mem_ctrl_m_1;
  logic [31:0]       readdata_m_0, readdata_m_1;
  logic              stall_m;
  logic [CNT_W-1:0]  conflict_count;

  mem_lane_arbiter_if mif();

  mem_lane_arbiter #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .aluout_m_0     (aluout_m_0),
    .aluout_m_1     (aluout_m_1),
    .writedata_m_0  (writedata_m_0),
    .writedata_m_1  (writedata_m_1),
    .mem_ctrl_m_0   (mem_ctrl_m_0),
    .mem_ctrl_m_1   (mem_ctrl_m_1),
    .readdata_m_0   (readdata_m_0),
    .readdata_m_1   (readdata_m_1),
    .stall_m        (stall_m),
    .mem            (mif),
    .conflict_count (conflict_count)
  );

  always #5 clk = ~clk;

  // Data memory: combinational read, write on the rising edge.
  logic [31:0] dmem [256] = '{default: 32'd0};
  assign mif.mem_rdata = dmem[mif.mem_addr[7:0]];
  always @(posedge clk) if (mif.mem_we) dmem[mif.mem_addr[7:0]] <= mif.mem_wdata;

  typedef struct {
    logic        stall;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    int          cnt;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] refmem [256];
  int          mcnt;

  function automatic exp_t mk(input logic st, input logic [31:0] r0, input logic [31:0] r1,
                              input logic [3:0] c, input logic [31:0] a, input logic [31:0] w,
                              input int cnt);
    exp_t e;
    e.stall = st;  e.rd0 = r0;  e.rd1 = r1;
    e.we    = c[3];
    e.re    = ~c[3] & c[2];
    e.addr  = a;   e.wdata = w; e.size = c[1:0];
    e.cnt   = cnt;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  exp_t me;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("stall_m",        32'(stall_m),        32'(me.stall));
      chk("readdata_m_0",   readdata_m_0,        me.rd0);
      chk("readdata_m_1",   readdata_m_1,        me.rd1);
      chk("mem_we",         32'(mif.mem_we),     32'(me.we));
      chk("mem_re",         32'(mif.mem_re),     32'(me.re));
      chk("mem_addr",       mif.mem_addr,        me.addr);
      chk("mem_wdata",      mif.mem_wdata,       me.wdata);
      chk("mem_size",       32'(mif.mem_size),   32'(me.size));
      chk("conflict_count", 32'(conflict_count), 32'(me.cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Program-order reference: lane 0 then lane 1, one memory access per cycle.
  task automatic bundle(input logic [3:0] c0, input logic [31:0] a0, input logic [31:0] w0,
                        input logic [3:0] c1, input logic [31:0] a1, input logic [31:0] w1);
    logic act0, act1, ld0, ld1;
    logic [31:0] h;
    int n;
    mem_ctrl_m_0 = c0; aluout_m_0 = a0; writedata_m_0 = w0;
    mem_ctrl_m_1 = c1; aluout_m_1 = a1; writedata_m_1 = w1;
    act0 = c0[3] | c0[2];  ld0 = ~c0[3] & c0[2];
    act1 = c1[3] | c1[2];  ld1 = ~c1[3] & c1[2];
    if (act0 && act1) begin
      h = ld0 ? refmem[a0[7:0]] : 32'd0;
      q.push_back(mk(1'b1, h, 32'd0, c0, a0, w0, mcnt));
      if (c0[3]) refmem[a0[7:0]] = w0;
      if (mcnt < CMAX) mcnt++;
      q.push_back(mk(1'b0, h, ld1 ? refmem[a1[7:0]] : 32'd0, c1, a1, w1, mcnt));
      if (c1[3]) refmem[a1[7:0]] = w1;
      n = 2;
    end else if (act0) begin
      q.push_back(mk(1'b0, ld0 ? refmem[a0[7:0]] : 32'd0, 32'd0, c0, a0, w0, mcnt));
      if (c0[3]) refmem[a0[7:0]] = w0;
      n = 1;
    end else if (act1) begin
      q.push_back(mk(1'b0, 32'd0, ld1 ? refmem[a1[7:0]] : 32'd0, c1, a1, w1, mcnt));
      if (c1[3]) refmem[a1[7:0]] = w1;
      n = 1;
    end else begin
      q.push_back(mk(1'b0, 32'd0, 32'd0, 4'b0000, 32'd0, 32'd0, mcnt));
      n = 1;
    end
    repeat (n) step();
  endtask

  function automatic logic [3:0] rnd_ctrl();
    logic [1:0] sz;
    sz = 2'($urandom_range(0, 3));
    case ($urandom_range(0, 3))
      0:       return {2'b00, sz};
      1:       return {2'b01, sz};
      default: return {1'b1, 1'($urandom_range(0, 1)), sz};
    endcase
  endfunction

  localparam logic [3:0] ST = 4'b1010;
  localparam logic [3:0] LD = 4'b0110;
  localparam logic [3:0] NO = 4'b0000;

  initial begin
    int guard;
    for (int i = 0; i < 256; i++) refmem[i] = 32'd0;
    mcnt = 0;
    reset = 1'b1;
    mem_ctrl_m_0 = NO; mem_ctrl_m_1 = NO;
    aluout_m_0 = 0; aluout_m_1 = 0; writedata_m_0 = 0; writedata_m_1 = 0;
    repeat (2) @(posedge clk);
    #1;
    q.push_back(mk(1'b0, 32'd0, 32'd0, NO, 32'd0, 32'd0, 0));
    step();
    reset = 1'b0;

    bundle(ST, 10, 30, NO, 0, 0);
    bundle(LD, 10, 0, NO, 0, 0);
    bundle(NO, 0, 0, ST, 70, 80);
    bundle(NO, 0, 0, LD, 70, 0);
    bundle(ST, 3, 2, ST, 1, 4);
    bundle(LD, 3, 0, NO, 0, 0);
    bundle(NO, 0, 0, LD, 1, 0);
    bundle(ST, 50, 60, LD, 50, 0);
    bundle(ST, 12, 100, ST, 12, 400);
    bundle(LD, 12, 0, NO, 0, 0);
    bundle(LD, 10, 0, LD, 3, 0);
    bundle(NO, 0, 0, NO, 0, 0);

    // Reset lands in the SECOND cycle; lane 1's store must be dropped.
    mem_ctrl_m_0 = ST; aluout_m_0 = 21; writedata_m_0 = 7;
    mem_ctrl_m_1 = ST; aluout_m_1 = 20; writedata_m_1 = 99;
    q.push_back(mk(1'b1, 32'd0, 32'd0, ST, 32'd21, 32'd7, mcnt));
    refmem[21] = 7;
    if (mcnt < CMAX) mcnt++;
    step();
    reset = 1'b1;
    q.push_back(mk(1'b0, 32'd0, 32'd0, NO, 32'd0, 32'd0, mcnt));
    step();
    reset = 1'b0;
    mcnt = 0;
    bundle(LD, 20, 0, NO, 0, 0);
    bundle(LD, 21, 0, NO, 0, 0);

    for (int i = 0; i < 5; i++) bundle(LD, 10, 0, ST, 40 + i, i);

    for (int i = 0; i < 300; i++)
      bundle(rnd_ctrl(), $urandom_range(0, 15), $urandom, rnd_ctrl(), $urandom_range(0, 15), $urandom);

    bundle(NO, 0, 0, NO, 0, 0);
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached, expected completion", $time);
    $fatal(1, "watchdog");
  end
endmodule
